// File: rtl/p405s_gpr_wb_addr_pipe.sv
// p405s_gpr_wb_addr_pipe: GPR writeback address pipeline (wb stage plus load-writeback stage)
module p405s_gpr_wb_addr_pipe (
  input  logic        i_cb,
  input  logic        i_reset,
  input  logic [4:0]  i_exe_lp_addr,
  input  logic [4:0]  i_exe_rp_addr,
  input  logic        i_exe_lp_en,
  input  logic        i_exe_rp_en,
  input  logic        i_exe_adv,
  input  logic        i_wb_adv,
  input  logic        i_wb_flush,
  input  logic        i_dcu_ld_data_val,
  output logic [4:0]  o_wb_lp_addr,
  output logic [4:0]  o_pcl_wb_rp_addr,
  output logic [4:0]  o_pcl_lwb_lp_addr,
  output logic        o_wb_full_l2,
  output logic        o_lwb_full_l2,
  output logic [4:0]  o_wb_rp_addr_neg,
  output logic [4:0]  o_lwb_lp_addr_neg,
  output logic        o_gpr_rp_wr_en,
  output logic        o_gpr_lp_wr_en,
  output logic        o_wb_hold,
  output logic [31:0] o_pend_ld_mask,
  output logic        o_wr_collision
);
  logic        r_wb_full, r_wb_lp_en, r_wb_rp_en, r_lwb_full;
  logic [4:0]  r_wb_lp_addr, r_wb_rp_addr, r_lwb_lp_addr;
  logic [31:0] r_pend_ld_mask, w_set, w_clr;
  logic        w_hold, w_wb_go, w_cap, w_xfer, w_lwb_done, w_rp_wr, w_col;
  assign w_hold     = r_wb_full & r_wb_lp_en & r_lwb_full & ~i_dcu_ld_data_val;
  assign w_wb_go    = r_wb_full & i_wb_adv & ~w_hold;
  // A new entry is accepted only into an empty or draining wb; flush always wins.
  assign w_cap      = i_exe_adv & (~r_wb_full | w_wb_go) & ~i_wb_flush;
  assign w_xfer     = w_wb_go & r_wb_lp_en & ~i_wb_flush;
  assign w_lwb_done = r_lwb_full & i_dcu_ld_data_val;
  assign w_rp_wr    = w_wb_go & r_wb_rp_en & ~i_wb_flush;
  assign w_col      = w_rp_wr & w_lwb_done & (r_wb_rp_addr == r_lwb_lp_addr);
  for (genvar g = 0; g < 32; g++) begin : g_mask
    assign w_set[g] = w_xfer & (r_wb_lp_addr == 5'(g));
    assign w_clr[g] = w_lwb_done & (r_lwb_lp_addr == 5'(g));
  end
  always_ff @(posedge i_cb) begin
    if (i_reset) begin
      r_wb_full      <= 1'b0;
      r_wb_lp_en     <= 1'b0;
      r_wb_rp_en     <= 1'b0;
      r_lwb_full     <= 1'b0;
      r_wb_lp_addr   <= '0;
      r_wb_rp_addr   <= '0;
      r_lwb_lp_addr  <= '0;
      r_pend_ld_mask <= '0;
    end else begin
      if (w_cap) begin
        r_wb_lp_addr <= i_exe_lp_addr;
        r_wb_rp_addr <= i_exe_rp_addr;
        r_wb_lp_en   <= i_exe_lp_en;
        r_wb_rp_en   <= i_exe_rp_en;
      end
      r_wb_full      <= w_cap | (r_wb_full & ~w_wb_go & ~i_wb_flush);
      r_lwb_full     <= w_xfer | (r_lwb_full & ~i_dcu_ld_data_val);
      if (w_xfer) r_lwb_lp_addr <= r_wb_lp_addr;
      r_pend_ld_mask <= (r_pend_ld_mask & ~w_clr) | w_set;
    end
  end
  assign o_wb_lp_addr      = r_wb_lp_addr;
  assign o_pcl_wb_rp_addr  = r_wb_rp_addr;
  assign o_pcl_lwb_lp_addr = r_lwb_lp_addr;
  assign o_wb_full_l2      = r_wb_full;
  assign o_lwb_full_l2     = r_lwb_full;
  assign o_wb_rp_addr_neg  = ~r_wb_rp_addr;
  assign o_lwb_lp_addr_neg = ~r_lwb_lp_addr;
  assign o_pend_ld_mask    = r_pend_ld_mask;
  assign o_wb_hold         = w_hold & ~i_reset;
  assign o_gpr_rp_wr_en    = w_rp_wr & ~i_reset;
  assign o_wr_collision    = w_col & ~i_reset;
  assign o_gpr_lp_wr_en    = w_lwb_done & ~w_col & ~i_reset;
endmodule

// File: tb/tb_p405s_gpr_wb_addr_pipe.sv
// tb_p405s_gpr_wb_addr_pipe: per-cycle directed vectors with hand-computed expectations
module tb_p405s_gpr_wb_addr_pipe;
  logic        cb = 1'b0;
  logic        rst, lp_en, rp_en, exe_adv, wb_adv, flush, dval;
  logic [4:0]  lp_addr, rp_addr;
  logic [4:0]  wb_lp, wb_rp, lwb_lp, wb_rp_neg, lwb_lp_neg;
  logic        wb_full, lwb_full, rp_wr, lp_wr, hold, col;
  logic [31:0] mask;
  int          n_cmp = 0, n_bad = 0;
  always #5 cb = ~cb;
  p405s_gpr_wb_addr_pipe dut (
    .i_cb(cb), .i_reset(rst), .i_exe_lp_addr(lp_addr), .i_exe_rp_addr(rp_addr),
    .i_exe_lp_en(lp_en), .i_exe_rp_en(rp_en), .i_exe_adv(exe_adv), .i_wb_adv(wb_adv),
    .i_wb_flush(flush), .i_dcu_ld_data_val(dval),
    .o_wb_lp_addr(wb_lp), .o_pcl_wb_rp_addr(wb_rp), .o_pcl_lwb_lp_addr(lwb_lp),
    .o_wb_full_l2(wb_full), .o_lwb_full_l2(lwb_full),
    .o_wb_rp_addr_neg(wb_rp_neg), .o_lwb_lp_addr_neg(lwb_lp_neg),
    .o_gpr_rp_wr_en(rp_wr), .o_gpr_lp_wr_en(lp_wr), .o_wb_hold(hold),
    .o_pend_ld_mask(mask), .o_wr_collision(col)
  );
  typedef struct {
    string      nm;
    logic       rst, ea, lpe;
    logic [4:0] lpa;
    logic       rpe;
    logic [4:0] rpa;
    logic       wa, fl, dv;
    logic       wbf, lwbf;
    logic [4:0] wlp, wrp, llp;
    logic [31:0] msk;
    logic       rpw, lpw, hld, cl;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(string nm, logic r, logic ea, logic lpe, logic [4:0] lpa,
                              logic rpe, logic [4:0] rpa, logic wa, logic fl, logic dv,
                              logic wbf, logic lwbf, logic [4:0] wlp, logic [4:0] wrp,
                              logic [4:0] llp, logic [31:0] msk,
                              logic rpw, logic lpw, logic hld, logic cl);
    vec_t v;
    v.nm = nm; v.rst = r; v.ea = ea; v.lpe = lpe; v.lpa = lpa; v.rpe = rpe; v.rpa = rpa;
    v.wa = wa; v.fl = fl; v.dv = dv; v.wbf = wbf; v.lwbf = lwbf; v.wlp = wlp; v.wrp = wrp;
    v.llp = llp; v.msk = msk; v.rpw = rpw; v.lpw = lpw; v.hld = hld; v.cl = cl;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    logic [62:0] got, exp;
    rst = v.rst; exe_adv = v.ea; lp_en = v.lpe; lp_addr = v.lpa; rp_en = v.rpe;
    rp_addr = v.rpa; wb_adv = v.wa; flush = v.fl; dval = v.dv;
    @(negedge cb);
    got = {wb_full, lwb_full, wb_lp, wb_rp, lwb_lp, wb_rp_neg, lwb_lp_neg, mask,
           rp_wr, lp_wr, hold, col};
    exp = {v.wbf, v.lwbf, v.wlp, v.wrp, v.llp, ~v.wrp, ~v.llp, v.msk,
           v.rpw, v.lpw, v.hld, v.cl};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", v.nm, got, exp);
    end
    @(posedge cb);
    #1;
  endtask
  initial begin
    //                 name     r ea le la   re ra  wa fl dv | wbf lwf wlp wrp llp msk        rpw lpw hld col
    tbl.push_back(mk("reset",   1,0,0,5'd0, 0,5'd0, 0,0,0,   0,0,5'd0,5'd0,5'd0,32'h0,       0,0,0,0));
    tbl.push_back(mk("alu_iss", 0,1,0,5'd0, 1,5'd7, 1,0,0,   0,0,5'd0,5'd0,5'd0,32'h0,       0,0,0,0));
    tbl.push_back(mk("alu_wb",  0,0,0,5'd0, 0,5'd0, 1,0,0,   1,0,5'd0,5'd7,5'd0,32'h0,       1,0,0,0));
    tbl.push_back(mk("ld3_iss", 0,1,1,5'd3, 0,5'd0, 1,0,0,   0,0,5'd0,5'd7,5'd0,32'h0,       0,0,0,0));
    tbl.push_back(mk("ld3_wb",  0,0,0,5'd0, 0,5'd0, 1,0,0,   1,0,5'd3,5'd0,5'd0,32'h0,       0,0,0,0));
    tbl.push_back(mk("ld3_w1",  0,0,0,5'd0, 0,5'd0, 1,0,0,   0,1,5'd3,5'd0,5'd3,32'h8,       0,0,0,0));
    tbl.push_back(mk("ld3_w2",  0,0,0,5'd0, 0,5'd0, 1,0,0,   0,1,5'd3,5'd0,5'd3,32'h8,       0,0,0,0));
    tbl.push_back(mk("ld3_w3",  0,0,0,5'd0, 0,5'd0, 1,0,0,   0,1,5'd3,5'd0,5'd3,32'h8,       0,0,0,0));
    tbl.push_back(mk("ld3_dat", 0,0,0,5'd0, 0,5'd0, 1,0,1,   0,1,5'd3,5'd0,5'd3,32'h8,       0,1,0,0));
    tbl.push_back(mk("ld3_clr", 0,0,0,5'd0, 0,5'd0, 1,0,0,   0,0,5'd3,5'd0,5'd3,32'h0,       0,0,0,0));
    tbl.push_back(mk("ld4_iss", 0,1,1,5'd4, 0,5'd0, 1,0,0,   0,0,5'd3,5'd0,5'd3,32'h0,       0,0,0,0));
    tbl.push_back(mk("ld5_iss", 0,1,1,5'd5, 0,5'd0, 1,0,0,   1,0,5'd4,5'd0,5'd3,32'h0,       0,0,0,0));
    tbl.push_back(mk("hold1",   0,0,0,5'd0, 0,5'd0, 1,0,0,   1,1,5'd5,5'd0,5'd4,32'h10,      0,0,1,0));
    tbl.push_back(mk("hold2",   0,0,0,5'd0, 0,5'd0, 1,0,0,   1,1,5'd5,5'd0,5'd4,32'h10,      0,0,1,0));
    tbl.push_back(mk("b2b_dat", 0,0,0,5'd0, 0,5'd0, 1,0,1,   1,1,5'd5,5'd0,5'd4,32'h10,      0,1,0,0));
    tbl.push_back(mk("ld5_lwb", 0,0,0,5'd0, 0,5'd0, 1,0,0,   0,1,5'd5,5'd0,5'd5,32'h20,      0,0,0,0));
    tbl.push_back(mk("ld5_dat", 0,0,0,5'd0, 0,5'd0, 1,0,1,   0,1,5'd5,5'd0,5'd5,32'h20,      0,1,0,0));
    tbl.push_back(mk("ld9_iss", 0,1,1,5'd9, 0,5'd0, 1,0,0,   0,0,5'd5,5'd0,5'd5,32'h0,       0,0,0,0));
    tbl.push_back(mk("r9_iss",  0,1,0,5'd0, 1,5'd9, 1,0,0,   1,0,5'd9,5'd0,5'd5,32'h0,       0,0,0,0));
    tbl.push_back(mk("collide", 0,0,0,5'd0, 0,5'd0, 1,0,1,   1,1,5'd0,5'd9,5'd9,32'h200,     1,0,0,1));
    tbl.push_back(mk("post_col",0,0,0,5'd0, 0,5'd0, 0,0,0,   0,0,5'd0,5'd9,5'd9,32'h0,       0,0,0,0));
    tbl.push_back(mk("ld6_iss", 0,1,1,5'd6, 0,5'd0, 1,0,0,   0,0,5'd0,5'd9,5'd9,32'h0,       0,0,0,0));
    tbl.push_back(mk("ld10_iss",0,1,1,5'd10,1,5'd11,1,0,0,   1,0,5'd6,5'd0,5'd9,32'h0,       0,0,0,0));
    tbl.push_back(mk("flush_ld",0,1,1,5'd13,1,5'd14,1,1,0,   1,1,5'd10,5'd11,5'd6,32'h40,    0,0,1,0));
    tbl.push_back(mk("post_fl", 0,0,0,5'd0, 0,5'd0, 1,0,0,   0,1,5'd10,5'd11,5'd6,32'h40,    0,0,0,0));
    tbl.push_back(mk("ld6_dat", 0,0,0,5'd0, 0,5'd0, 1,0,1,   0,1,5'd10,5'd11,5'd6,32'h40,    0,1,0,0));
    tbl.push_back(mk("r2_iss",  0,1,0,5'd0, 1,5'd2, 1,0,0,   0,0,5'd10,5'd11,5'd6,32'h0,     0,0,0,0));
    tbl.push_back(mk("flush_r", 0,0,0,5'd0, 0,5'd0, 1,1,0,   1,0,5'd0,5'd2,5'd6,32'h0,       0,0,0,0));
    tbl.push_back(mk("post_flr",0,0,0,5'd0, 0,5'd0, 1,0,0,   0,0,5'd0,5'd2,5'd6,32'h0,       0,0,0,0));
    rst = 1'b1; exe_adv = 1'b0; lp_en = 1'b0; rp_en = 1'b0; lp_addr = '0; rp_addr = '0;
    wb_adv = 1'b0; flush = 1'b0; dval = 1'b0;
    repeat (2) @(posedge cb);
    #1;
    foreach (tbl[i]) apply(tbl[i]);
    // exeAdv into a stalled full wb must be ignored
    apply(mk("r20_iss", 0,1,0,5'd0, 1,5'd20,0,0,0, 0,0,5'd0,5'd2,5'd6,32'h0,     0,0,0,0));
    apply(mk("r21_err", 0,1,0,5'd0, 1,5'd21,0,0,0, 1,0,5'd0,5'd20,5'd6,32'h0,    0,0,0,0));
    apply(mk("r20_wb",  0,0,0,5'd0, 0,5'd0, 1,0,0, 1,0,5'd0,5'd20,5'd6,32'h0,    1,0,0,0));
    // reset in the middle of an outstanding load
    apply(mk("ld12_iss",0,1,1,5'd12,0,5'd0, 1,0,0, 0,0,5'd0,5'd20,5'd6,32'h0,    0,0,0,0));
    apply(mk("ld12_wb", 0,0,0,5'd0, 0,5'd0, 1,0,0, 1,0,5'd12,5'd0,5'd6,32'h0,    0,0,0,0));
    apply(mk("rst_mid", 1,0,0,5'd0, 0,5'd0, 1,0,1, 0,1,5'd12,5'd0,5'd12,32'h1000,0,0,0,0));
    apply(mk("post_rst",0,0,0,5'd0, 0,5'd0, 0,0,1, 0,0,5'd0,5'd0,5'd0,32'h0,     0,0,0,0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
